// File: rtl/multimode_demod_if.sv
// Sample-stream and recovered-bit signals shared by the demodulator and whatever drives it.
interface multimode_demod_if;
    logic [1:0] mode;
    logic [6:0] sample_in;
    logic       sample_valid;
    logic       sym_sync;
    logic       bit_out;
    logic       bit_valid;
    logic       carrier_det;

    modport master (
        output mode, sample_in, sample_valid, sym_sync,
        input  bit_out, bit_valid, carrier_det
    );

    modport slave (
        input  mode, sample_in, sample_valid, sym_sync,
        output bit_out, bit_valid, carrier_det
    );
endinterface

// File: rtl/multimode_demod.sv
// ASK / FSK / BPSK symbol demodulator for a 7-bit offset-binary sample stream
// (64 = zero level); one bit is recovered per SPS valid samples.
module multimode_demod #(
    parameter int SPS         = 16,
    parameter int CARRIER_LEN = 8,
    parameter int ASK_THRESH  = 256,
    parameter int FSK_THRESH  = 6,
    parameter int ACC_W       = 12
) (
    input  logic               clk,
    input  logic               rst,
    multimode_demod_if.slave   bus
);
    localparam int SYM_W = $clog2(SPS);
    localparam int CAR_W = $clog2(CARRIER_LEN);
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SPS - 1);
    localparam logic [CAR_W-1:0] CAR_LAST = CAR_W'(CARRIER_LEN - 1);
    localparam logic [CAR_W-1:0] CAR_HALF = CAR_W'(CARRIER_LEN / 2);
    localparam logic [ACC_W-1:0] ASK_T    = ACC_W'(ASK_THRESH);
    localparam logic [ACC_W-1:0] FSK_T    = ACC_W'(FSK_THRESH);
    localparam logic [ACC_W-1:0] ACC_ONE  = ACC_W'(1'b1);

    logic [1:0]              mode_q_r;
    logic [SYM_W-1:0]        sym_cnt_r;
    logic [CAR_W-1:0]        car_cnt_r;
    logic [ACC_W-1:0]        energy_r;
    logic [ACC_W-1:0]        crossings_r;
    logic signed [ACC_W-1:0] corr_r;
    logic                    prev_sign_r;
    logic                    prev_valid_r;
    logic                    bit_out_r;
    logic                    bit_valid_r;
    logic                    carrier_det_r;

    logic                    sign_s;
    logic [6:0]              mag_s;
    logic signed [7:0]       d_s;
    logic signed [ACC_W-1:0] d_ext_s;
    logic [ACC_W-1:0]        energy_sum_s;
    logic [ACC_W-1:0]        cross_sum_s;
    logic signed [ACC_W-1:0] corr_sum_s;
    logic                    decision_s;
    logic                    clear_s;
    logic                    sym_end_s;

    // Per-sample arithmetic and the symbol decision on totals that include the current sample.
    always_comb begin
        sign_s  = (bus.sample_in >= 7'd64);
        d_s     = $signed({1'b0, bus.sample_in} - 8'd64);
        d_ext_s = {{(ACC_W-8){d_s[7]}}, d_s};
        if (sign_s) begin
            mag_s = bus.sample_in - 7'd64;
        end else begin
            mag_s = 7'd64 - bus.sample_in;
        end
        energy_sum_s = energy_r + {{(ACC_W-7){1'b0}}, mag_s};
        if (prev_valid_r && (sign_s != prev_sign_r)) begin
            cross_sum_s = crossings_r + ACC_ONE;
        end else begin
            cross_sum_s = crossings_r;
        end
        // First half of the reference carrier period counts as +1, second half as -1.
        if (car_cnt_r < CAR_HALF) begin
            corr_sum_s = corr_r + d_ext_s;
        end else begin
            corr_sum_s = corr_r - d_ext_s;
        end
        case (mode_q_r)
            2'b00:   decision_s = (energy_sum_s >= ASK_T);
            2'b01:   decision_s = (cross_sum_s >= FSK_T);
            2'b10:   decision_s = corr_sum_s[ACC_W-1];
            default: decision_s = 1'b0;
        endcase
        clear_s   = bus.sym_sync || (bus.mode != mode_q_r);
        sym_end_s = (sym_cnt_r == SYM_LAST);
    end

    // Symbol/carrier counters, accumulators and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q_r      <= 2'b00;
            sym_cnt_r     <= '0;
            car_cnt_r     <= '0;
            energy_r      <= '0;
            crossings_r   <= '0;
            corr_r        <= '0;
            prev_sign_r   <= 1'b0;
            prev_valid_r  <= 1'b0;
            bit_out_r     <= 1'b0;
            bit_valid_r   <= 1'b0;
            carrier_det_r <= 1'b0;
        end else begin
            mode_q_r    <= bus.mode;
            bit_valid_r <= 1'b0;
            if (clear_s) begin
                // A sample arriving with a clear is dropped; outputs keep their last values.
                sym_cnt_r    <= '0;
                car_cnt_r    <= '0;
                energy_r     <= '0;
                crossings_r  <= '0;
                corr_r       <= '0;
                prev_valid_r <= 1'b0;
            end else if (bus.sample_valid) begin
                prev_sign_r  <= sign_s;
                prev_valid_r <= 1'b1;
                car_cnt_r    <= (car_cnt_r == CAR_LAST) ? '0 : car_cnt_r + CAR_W'(1'b1);
                if (sym_end_s) begin
                    bit_valid_r   <= 1'b1;
                    bit_out_r     <= decision_s;
                    carrier_det_r <= (energy_sum_s >= ASK_T);
                    sym_cnt_r     <= '0;
                    energy_r      <= '0;
                    crossings_r   <= '0;
                    corr_r        <= '0;
                end else begin
                    sym_cnt_r   <= sym_cnt_r + SYM_W'(1'b1);
                    energy_r    <= energy_sum_s;
                    crossings_r <= cross_sum_s;
                    corr_r      <= corr_sum_s;
                end
            end else begin
                sym_cnt_r <= sym_cnt_r;
            end
        end
    end

    assign bus.bit_out     = bit_out_r;
    assign bus.bit_valid   = bit_valid_r;
    assign bus.carrier_det = carrier_det_r;
endmodule

// File: tb/tb_multimode_demod.sv
// Directed scoreboard bench for multimode_demod: stimulus pushes expected bits, a monitor pops on bit_valid.
module tb_multimode_demod;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    typedef struct {
        logic b;
        logic cd;
        int   cyc;
    } exp_t;
    exp_t sb[$];

    multimode_demod_if ifc();

    multimode_demod dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every bit_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && ifc.bit_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_bit_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("bit_out", int'(ifc.bit_out), int'(e.b));
                chk("carrier_det", int'(ifc.carrier_det), int'(e.cd));
                chk("bit_valid_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic logic [6:0] sample_at(input int i, input int half, input bit inv);
        logic hi;
        if (half == 0) return 7'd64;
        hi = (((i / half) % 2) == 0) ^ inv;
        return hi ? 7'd104 : 7'd24;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sync_pulse();
        ifc.sym_sync = 1'b1;
        idle(1);
        ifc.sym_sync = 1'b0;
    endtask

    // Send n samples of the pattern starting at index start; push an expectation after the last one.
    task automatic send(input int start, input int n, input int half, input bit inv,
                        input int gap, input bit push, input bit eb, input bit ecd);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            ifc.sample_in    = sample_at(start + k, half, inv);
            ifc.sample_valid = 1'b1;
            @(posedge clk);
            #1;
            ifc.sample_valid = 1'b0;
            if (push && (k == n - 1)) begin
                e.b   = eb;
                e.cd  = ecd;
                e.cyc = cyc;
                sb.push_back(e);
            end
            idle(gap);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifc.mode         = 2'b00;
        ifc.sample_in    = 7'd64;
        ifc.sample_valid = 1'b0;
        ifc.sym_sync     = 1'b0;
        idle(2);
        rst = 1'b0;
        chk("reset_bit_out", int'(ifc.bit_out), 0);
        chk("reset_bit_valid", int'(ifc.bit_valid), 0);
        chk("reset_carrier_det", int'(ifc.carrier_det), 0);

        // ASK: silence, then full-swing 104/24 alternation (energy 640)
        send(0, 16, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        send(0, 16, 1, 1'b0, 0, 1'b1, 1'b1, 1'b1);
        idle(2);

        // FSK: clear must keep last outputs
        ifc.mode = 2'b01;
        sync_pulse();
        chk("clear_keeps_bit_out", int'(ifc.bit_out), 1);
        chk("clear_keeps_carrier_det", int'(ifc.carrier_det), 1);
        send(0, 16, 4, 1'b0, 0, 1'b1, 1'b0, 1'b1);   // 3 crossings
        send(16, 16, 4, 1'b0, 0, 1'b1, 1'b0, 1'b1);  // 4 crossings
        sync_pulse();
        send(0, 16, 2, 1'b0, 0, 1'b1, 1'b1, 1'b1);   // 7 crossings
        send(16, 16, 2, 1'b0, 0, 1'b1, 1'b1, 1'b1);  // 8 crossings
        idle(2);

        // BPSK: +640 then -640
        ifc.mode = 2'b10;
        sync_pulse();
        send(0, 16, 4, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        send(0, 16, 4, 1'b1, 0, 1'b1, 1'b1, 1'b1);
        idle(1);

        // BPSK +640 with valid every third cycle
        sync_pulse();
        send(0, 16, 4, 1'b0, 2, 1'b1, 1'b0, 1'b1);
        idle(2);

        // Mode change mid-symbol discards the partial symbol
        ifc.mode = 2'b00;
        idle(1);
        send(0, 7, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        ifc.mode = 2'b10;
        idle(1);
        chk("mode_clear_no_pulse", int'(ifc.bit_valid), 0);
        chk("mode_clear_keeps_bit_out", int'(ifc.bit_out), 0);
        send(0, 16, 4, 1'b1, 0, 1'b1, 1'b1, 1'b1);
        idle(2);

        // Reset mid-symbol zeroes every output
        send(0, 5, 4, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle(1);
        chk("midrst_bit_out", int'(ifc.bit_out), 0);
        chk("midrst_bit_valid", int'(ifc.bit_valid), 0);
        chk("midrst_carrier_det", int'(ifc.carrier_det), 0);
        rst = 1'b0;
        idle(20);

        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
